// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg: shared state encoding and constants for the clock-enable strobe generator.
package ce_gen_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int BURST_CONTINUOUS = 0;
endpackage

// File: rtl/ce_div_counter.sv
// ce_div_counter: loadable down-counter with zero flag that paces the strobe period.
module ce_div_counter #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);
    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec) cnt <= cnt - 1'b1;

    assign zero = (cnt == '0);
endmodule

// File: rtl/ce_strobe_gen.sv
// ce_strobe_gen: programmable-rate clock-enable strobe with burst and continuous modes.
module ce_strobe_gen
    import ce_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DIV_WIDTH-1:0]   DIV,
    input  logic [BURST_WIDTH-1:0] BURST,
    input  logic                   START,
    input  logic                   STOP,
    output logic                   CE,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [BURST_WIDTH-1:0] COUNT
);
    state_t                 state;
    logic [DIV_WIDTH-1:0]   shadow_div;
    logic [BURST_WIDTH-1:0] shadow_burst;
    logic [BURST_WIDTH-1:0] count_next;
    logic                   zero, accept, advance;

    assign accept     = (state == IDLE) && START && !STOP;
    assign advance    = (state == RUN) && !STOP;
    assign count_next = COUNT + 1'b1;

    // Reloading on the strobe edge keeps the period at exactly shadow_div+1 clocks.
    ce_div_counter #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept || (advance && zero)),
        .load_val (accept ? DIV : shadow_div),
        .dec      (advance && !zero),
        .zero     (zero)
    );

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state        <= IDLE;
            shadow_div   <= '0;
            shadow_burst <= '0;
            COUNT        <= '0;
            CE           <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            CE   <= 1'b0;
            DONE <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    shadow_div   <= DIV;
                    shadow_burst <= BURST;
                    COUNT        <= '0;
                    state        <= RUN;
                    BUSY         <= 1'b1;
                end
            end else if (STOP) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end else if (zero) begin
                CE    <= 1'b1;
                COUNT <= count_next;
                if (shadow_burst != BURST_WIDTH'(BURST_CONTINUOUS) && count_next == shadow_burst) begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_ce_strobe_gen.sv
// tb_ce_strobe_gen: scoreboard bench comparing every cycle against a phase-counting reference model.
module tb_ce_strobe_gen;
    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, STOP = 1'b0;
    logic [15:0] DIV = '0;
    logic [7:0]  BURST = '0;
    logic        CE, BUSY, DONE;
    logic [7:0]  COUNT;

    always #5 CLK = ~CLK;

    ce_strobe_gen dut (
        .CLK(CLK), .RST(RST), .DIV(DIV), .BURST(BURST), .START(START), .STOP(STOP),
        .CE(CE), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT)
    );

    int n_vec = 0, n_err = 0, ce_seen = 0;
    logic [10:0] exp_q[$];

    bit          m_run, m_ce, m_done;
    logic [15:0] m_div;
    logic [7:0]  m_burst, m_count;
    int          m_phase;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts clocks since the last strobe upward instead of reloading.
    task automatic model_edge();
        m_ce = 0;
        m_done = 0;
        if (RST) begin
            m_run = 0; m_div = 0; m_burst = 0; m_count = 0; m_phase = 0;
        end else if (!m_run) begin
            if (START && !STOP) begin
                m_run = 1; m_div = DIV; m_burst = BURST; m_count = 0; m_phase = 0;
            end
        end else if (STOP) begin
            m_run = 0;
        end else if (m_phase == int'(m_div)) begin
            m_ce = 1;
            m_phase = 0;
            m_count = m_count + 8'd1;
            if (m_burst != 0 && m_count == m_burst) begin
                m_run = 0;
                m_done = 1;
            end
        end else begin
            m_phase++;
        end
    endtask

    task automatic cycle(input bit st, input bit sp, input logic [15:0] d, input logic [7:0] b);
        logic [10:0] e;
        START = st; STOP = sp; DIV = d; BURST = b;
        model_edge();
        exp_q.push_back({m_ce, m_run, m_done, m_count});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("ce", 16'(CE), 16'(e[10]));
        chk("busy", 16'(BUSY), 16'(e[9]));
        chk("done", 16'(DONE), 16'(e[8]));
        chk("count", 16'(COUNT), 16'(e[7:0]));
        if (CE) ce_seen++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, DIV, BURST);
    endtask

    initial begin
        idle(2);
        RST = 1'b0;
        idle(2);

        ce_seen = 0;
        cycle(1, 0, 16'd3, 8'd4);
        idle(20);
        chk("t1_nce", 16'(ce_seen), 16'd4);
        chk("t1_count", 16'(COUNT), 16'd4);

        ce_seen = 0;
        cycle(1, 0, 16'd0, 8'd5);
        idle(8);
        chk("t2_nce", 16'(ce_seen), 16'd5);

        ce_seen = 0;
        cycle(1, 0, 16'd2, 8'd0);
        idle(20);
        cycle(0, 1, 16'd2, 8'd0);
        idle(3);
        chk("t3_nce", 16'(ce_seen), 16'd6);
        chk("t3_count", 16'(COUNT), 16'd6);

        ce_seen = 0;
        cycle(1, 0, 16'd1, 8'd3);
        idle(5);
        cycle(0, 1, 16'd1, 8'd3);
        idle(3);
        chk("t4_nce", 16'(ce_seen), 16'd2);
        chk("t4_count", 16'(COUNT), 16'd2);

        ce_seen = 0;
        cycle(1, 0, 16'd4, 8'd2);
        idle(2);
        cycle(1, 0, 16'd0, 8'd2);
        idle(12);
        chk("t5_nce", 16'(ce_seen), 16'd2);
        cycle(1, 1, 16'd0, 8'd2);
        chk("t5_startstop_busy", 16'(BUSY), 16'd0);
        idle(2);

        cycle(1, 0, 16'd2, 8'd10);
        idle(7);
        #2 RST = 1'b1;
        #1;
        chk("t6_async_ce", 16'(CE), 16'd0);
        chk("t6_async_busy", 16'(BUSY), 16'd0);
        chk("t6_async_done", 16'(DONE), 16'd0);
        chk("t6_async_count", 16'(COUNT), 16'd0);
        idle(2);
        RST = 1'b0;
        ce_seen = 0;
        cycle(1, 0, 16'd1, 8'd3);
        idle(8);
        chk("t6_nce", 16'(ce_seen), 16'd3);
        chk("t6_count", 16'(COUNT), 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
